// File: rtl/isdu.sv
// ============================================================================
// Module      : isdu
// Description : SLC-3.2 instruction sequencer and decode unit (Moore FSM).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isdu #(
  parameter int MEM_WAIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Run,
  input  logic       i_Continue,
  input  logic [3:0] i_Opcode,
  input  logic       i_IR_5,
  input  logic       i_IR_11,
  input  logic       i_BEN,
  output logic       o_LD_MAR,
  output logic       o_LD_MDR,
  output logic       o_LD_IR,
  output logic       o_LD_BEN,
  output logic       o_LD_CC,
  output logic       o_LD_REG,
  output logic       o_LD_PC,
  output logic       o_LD_LED,
  output logic       o_GatePC,
  output logic       o_GateMDR,
  output logic       o_GateALU,
  output logic       o_GateMARMUX,
  output logic [1:0] o_PCMUX,
  output logic       o_DRMUX,
  output logic       o_SR1MUX,
  output logic       o_SR2MUX,
  output logic       o_ADDR1MUX,
  output logic [1:0] o_ADDR2MUX,
  output logic [1:0] o_ALUK,
  output logic       o_Mem_OE,
  output logic       o_Mem_WE
);

  localparam logic [2:0] c_LAST = 3'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_wait;
  logic       w_wait_st;
  logic       w_last;

  assign w_wait_st = (r_state == S33) || (r_state == S25) || (r_state == S16);
  assign w_last    = (r_wait == c_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= HALTED;
      r_wait  <= 3'd0;
    end else begin
      r_state <= w_next;
      // r_wait doubles as the "LED already pulsed" flag while in PAUSE1
      if (w_wait_st && (w_next == r_state))
        r_wait <= r_wait + 3'd1;
      else if ((r_state == PAUSE1) && (w_next == PAUSE1))
        r_wait <= 3'd1;
      else
        r_wait <= 3'd0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALTED: if (i_Run) w_next = S18;
      S18:    w_next = S33;
      S33:    if (w_last) w_next = S35;
      S35:    w_next = S32;
      S32: begin
        case (i_Opcode)
          4'b0001: w_next = S01;
          4'b0101: w_next = S05;
          4'b1001: w_next = S09;
          4'b0000: w_next = S00;
          4'b1100: w_next = S12;
          4'b0100: w_next = S04;
          4'b0110: w_next = S06;
          4'b0111: w_next = S07;
          4'b1101: w_next = PAUSE1;
          default: w_next = S18;
        endcase
      end
      S00:    w_next = i_BEN ? S22 : S18;
      S04:    w_next = i_IR_11 ? S21 : S20;
      S06:    w_next = S25;
      S25:    if (w_last) w_next = S27;
      S07:    w_next = S23;
      S23:    w_next = S16;
      S16:    if (w_last) w_next = S18;
      PAUSE1: if (i_Continue) w_next = PAUSE2;
      PAUSE2: if (!i_Continue) w_next = S18;
      S01, S05, S09, S22, S12, S21, S20, S27: w_next = S18;
      default: w_next = HALTED;
    endcase
  end

  always_comb begin
    o_LD_MAR     = 1'b0;
    o_LD_MDR     = 1'b0;
    o_LD_IR      = 1'b0;
    o_LD_BEN     = 1'b0;
    o_LD_CC      = 1'b0;
    o_LD_REG     = 1'b0;
    o_LD_PC      = 1'b0;
    o_LD_LED     = 1'b0;
    o_GatePC     = 1'b0;
    o_GateMDR    = 1'b0;
    o_GateALU    = 1'b0;
    o_GateMARMUX = 1'b0;
    o_PCMUX      = 2'b00;
    o_DRMUX      = 1'b0;
    o_SR1MUX     = 1'b0;
    o_SR2MUX     = 1'b0;
    o_ADDR1MUX   = 1'b0;
    o_ADDR2MUX   = 2'b00;
    o_ALUK       = 2'b00;
    o_Mem_OE     = 1'b1;
    o_Mem_WE     = 1'b1;
    case (r_state)
      S18: begin
        o_GatePC = 1'b1;
        o_LD_MAR = 1'b1;
        o_LD_PC  = 1'b1;
      end
      S33, S25: begin
        o_Mem_OE = 1'b0;
        o_LD_MDR = w_last;
      end
      S35: begin
        o_GateMDR = 1'b1;
        o_LD_IR   = 1'b1;
      end
      S32: o_LD_BEN = 1'b1;
      S01, S05: begin
        o_SR1MUX  = 1'b1;
        o_SR2MUX  = i_IR_5;
        o_ALUK    = (r_state == S05) ? 2'b01 : 2'b00;
        o_GateALU = 1'b1;
        o_LD_REG  = 1'b1;
        o_LD_CC   = 1'b1;
      end
      S09: begin
        o_SR1MUX  = 1'b1;
        o_ALUK    = 2'b10;
        o_GateALU = 1'b1;
        o_LD_REG  = 1'b1;
        o_LD_CC   = 1'b1;
      end
      S22: begin
        o_ADDR2MUX = 2'b10;
        o_PCMUX    = 2'b10;
        o_LD_PC    = 1'b1;
      end
      S12, S20: begin
        o_SR1MUX  = 1'b1;
        o_ALUK    = 2'b11;
        o_GateALU = 1'b1;
        o_PCMUX   = 2'b01;
        o_LD_PC   = 1'b1;
      end
      S04: begin
        o_GatePC = 1'b1;
        o_DRMUX  = 1'b1;
        o_LD_REG = 1'b1;
      end
      S21: begin
        o_ADDR2MUX = 2'b11;
        o_PCMUX    = 2'b10;
        o_LD_PC    = 1'b1;
      end
      S06, S07: begin
        o_SR1MUX     = 1'b1;
        o_ADDR1MUX   = 1'b1;
        o_ADDR2MUX   = 2'b01;
        o_GateMARMUX = 1'b1;
        o_LD_MAR     = 1'b1;
      end
      S27: begin
        o_GateMDR = 1'b1;
        o_LD_REG  = 1'b1;
        o_LD_CC   = 1'b1;
      end
      S23: begin
        o_ALUK    = 2'b11;
        o_GateALU = 1'b1;
        o_LD_MDR  = 1'b1;
      end
      S16:    o_Mem_WE = 1'b0;
      PAUSE1: o_LD_LED = (r_wait == 3'd0);
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_isdu.sv
// ============================================================================
// Module      : tb_isdu
// Description : Directed self-checking bench for the isdu sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isdu;

  logic       clk;
  logic       i_Reset, i_Run, i_Continue, i_IR_5, i_IR_11, i_BEN;
  logic [3:0] i_Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
  logic [23:0] obs;

  int n_vec  = 0;
  int n_miss = 0;

  isdu #(.MEM_WAIT(2)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Run(i_Run), .i_Continue(i_Continue),
    .i_Opcode(i_Opcode), .i_IR_5(i_IR_5), .i_IR_11(i_IR_11), .i_BEN(i_BEN),
    .o_LD_MAR(LD_MAR), .o_LD_MDR(LD_MDR), .o_LD_IR(LD_IR), .o_LD_BEN(LD_BEN),
    .o_LD_CC(LD_CC), .o_LD_REG(LD_REG), .o_LD_PC(LD_PC), .o_LD_LED(LD_LED),
    .o_GatePC(GatePC), .o_GateMDR(GateMDR), .o_GateALU(GateALU),
    .o_GateMARMUX(GateMARMUX), .o_PCMUX(PCMUX), .o_DRMUX(DRMUX),
    .o_SR1MUX(SR1MUX), .o_SR2MUX(SR2MUX), .o_ADDR1MUX(ADDR1MUX),
    .o_ADDR2MUX(ADDR2MUX), .o_ALUK(ALUK), .o_Mem_OE(Mem_OE), .o_Mem_WE(Mem_WE)
  );

  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  localparam logic [23:0] B_LD_MAR  = 24'd1 << 23;
  localparam logic [23:0] B_LD_MDR  = 24'd1 << 22;
  localparam logic [23:0] B_LD_IR   = 24'd1 << 21;
  localparam logic [23:0] B_LD_BEN  = 24'd1 << 20;
  localparam logic [23:0] B_LD_CC   = 24'd1 << 19;
  localparam logic [23:0] B_LD_REG  = 24'd1 << 18;
  localparam logic [23:0] B_LD_PC   = 24'd1 << 17;
  localparam logic [23:0] B_LD_LED  = 24'd1 << 16;
  localparam logic [23:0] B_GPC     = 24'd1 << 15;
  localparam logic [23:0] B_GMDR    = 24'd1 << 14;
  localparam logic [23:0] B_GALU    = 24'd1 << 13;
  localparam logic [23:0] B_GMAR    = 24'd1 << 12;
  localparam logic [23:0] B_PCMUX1  = 24'd1 << 10;
  localparam logic [23:0] B_PCMUX2  = 24'd2 << 10;
  localparam logic [23:0] B_DRMUX   = 24'd1 << 9;
  localparam logic [23:0] B_SR1     = 24'd1 << 8;
  localparam logic [23:0] B_SR2     = 24'd1 << 7;
  localparam logic [23:0] B_A1      = 24'd1 << 6;
  localparam logic [23:0] B_A2_1    = 24'd1 << 4;
  localparam logic [23:0] B_A2_2    = 24'd2 << 4;
  localparam logic [23:0] B_A2_3    = 24'd3 << 4;
  localparam logic [23:0] B_ALUK1   = 24'd1 << 2;
  localparam logic [23:0] B_ALUK2   = 24'd2 << 2;
  localparam logic [23:0] B_ALUK3   = 24'd3 << 2;
  localparam logic [23:0] B_OE      = 24'd1 << 1;
  localparam logic [23:0] B_WE      = 24'd1;

  localparam logic [23:0] IDLE   = B_OE | B_WE;
  localparam logic [23:0] E_S18  = IDLE | B_GPC | B_LD_MAR | B_LD_PC;
  localparam logic [23:0] E_RDA  = B_WE;
  localparam logic [23:0] E_RDB  = B_WE | B_LD_MDR;
  localparam logic [23:0] E_S35  = IDLE | B_GMDR | B_LD_IR;
  localparam logic [23:0] E_S32  = IDLE | B_LD_BEN;
  localparam logic [23:0] E_ADD1 = IDLE | B_SR1 | B_SR2 | B_GALU | B_LD_REG | B_LD_CC;
  localparam logic [23:0] E_AND0 = IDLE | B_SR1 | B_ALUK1 | B_GALU | B_LD_REG | B_LD_CC;
  localparam logic [23:0] E_NOT  = IDLE | B_SR1 | B_ALUK2 | B_GALU | B_LD_REG | B_LD_CC;
  localparam logic [23:0] E_S22  = IDLE | B_PCMUX2 | B_A2_2 | B_LD_PC;
  localparam logic [23:0] E_JMP  = IDLE | B_SR1 | B_ALUK3 | B_GALU | B_PCMUX1 | B_LD_PC;
  localparam logic [23:0] E_S04  = IDLE | B_GPC | B_DRMUX | B_LD_REG;
  localparam logic [23:0] E_S21  = IDLE | B_A2_3 | B_PCMUX2 | B_LD_PC;
  localparam logic [23:0] E_S06  = IDLE | B_SR1 | B_A1 | B_A2_1 | B_GMAR | B_LD_MAR;
  localparam logic [23:0] E_S27  = IDLE | B_GMDR | B_LD_REG | B_LD_CC;
  localparam logic [23:0] E_S23  = IDLE | B_ALUK3 | B_GALU | B_LD_MDR;
  localparam logic [23:0] E_WR   = B_OE;
  localparam logic [23:0] E_P1   = IDLE | B_LD_LED;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resets the DUT and presents Run for one edge; returns at the negedge before that edge.
  task automatic launch(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    @(negedge clk);
    i_Reset = 1'b1; i_Run = 1'b0; i_Continue = 1'b0;
    i_Opcode = op; i_IR_5 = ir5; i_IR_11 = ir11; i_BEN = ben;
    @(negedge clk);
    i_Reset = 1'b0; i_Run = 1'b1;
  endtask

  task automatic run_seq(input string name, input logic [3:0] op, input logic ir5,
                         input logic ir11, input logic ben);
    logic [23:0] exp [$];
    exp = '{E_S18, E_RDA, E_RDB, E_S35, E_S32};
    case (name)
      "add":   exp = {exp, E_ADD1, E_S18};
      "and":   exp = {exp, E_AND0, E_S18};
      "not":   exp = {exp, E_NOT, E_S18};
      "br_t":  exp = {exp, IDLE, E_S22, E_S18};
      "br_nt": exp = {exp, IDLE, E_S18, E_RDA};
      "jmp":   exp = {exp, E_JMP, E_S18};
      "jsr":   exp = {exp, E_S04, E_S21, E_S18};
      "jsrr":  exp = {exp, E_S04, E_JMP, E_S18};
      "ldr":   exp = {exp, E_S06, E_RDA, E_RDB, E_S27, E_S18};
      "str":   exp = {exp, E_S06, E_S23, E_WR, E_WR, E_S18, E_RDA};
      default: exp = {exp, E_S18, E_RDA};
    endcase
    launch(op, ir5, ir11, ben);
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge clk);
      i_Run = 1'b0;
      n_vec++;
      if (obs !== exp[i]) begin
        n_miss++;
        $display("FAIL %s cycle %0d: got %h want %h", name, i + 1, obs, exp[i]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    i_Reset = 1'b1; i_Run = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== IDLE) begin
      n_miss++; $display("FAIL reset_prio: got %h want %h", obs, IDLE);
    end
    i_Run = 1'b0;
    @(negedge clk);
    i_Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== IDLE) begin
        n_miss++; $display("FAIL halted_idle %0d: got %h want %h", i, obs, IDLE);
      end
    end
  endtask

  task automatic test_opcodes;
    run_seq("add",   4'b0001, 1'b1, 1'b0, 1'b0);
    run_seq("and",   4'b0101, 1'b0, 1'b0, 1'b0);
    run_seq("not",   4'b1001, 1'b1, 1'b0, 1'b0);
    run_seq("br_t",  4'b0000, 1'b0, 1'b0, 1'b1);
    run_seq("br_nt", 4'b0000, 1'b0, 1'b0, 1'b0);
    run_seq("jmp",   4'b1100, 1'b0, 1'b0, 1'b0);
    run_seq("jsr",   4'b0100, 1'b0, 1'b1, 1'b0);
    run_seq("jsrr",  4'b0100, 1'b0, 1'b0, 1'b0);
    run_seq("ldr",   4'b0110, 1'b0, 1'b0, 1'b0);
    run_seq("str",   4'b0111, 1'b1, 1'b0, 1'b0);
    run_seq("nop",   4'b1111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pause;
    logic [23:0] want;
    launch(4'b1101, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      i_Run = 1'b0;
      if (i == 16) i_Continue = 1'b1;
      if (i == 19) i_Continue = 1'b0;
      case (i)
        1: want = E_S18;  2: want = E_RDA; 3: want = E_RDB;
        4: want = E_S35;  5: want = E_S32; 6: want = E_P1;
        20: want = E_S18; 21: want = E_RDA; 22: want = E_RDB;
        default: want = IDLE;
      endcase
      n_vec++;
      if (obs !== want) begin
        n_miss++; $display("FAIL pause cycle %0d: got %h want %h", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid_access(input string name, input logic [3:0] op, input int cut);
    launch(op, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= cut; i++) begin
      @(negedge clk);
      i_Run = 1'b0;
    end
    n_vec++;
    if (obs === IDLE) begin
      n_miss++; $display("FAIL %s_pre: got %h want a strobe low", name, obs);
    end
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (obs !== IDLE) begin
        n_miss++; $display("FAIL %s_halt %0d: got %h want %h", name, i, obs, IDLE);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_run_held;
    logic [23:0] exp [$];
    exp = '{E_S18, E_RDA, E_RDB, E_S35, E_S32, E_ADD1, E_S18, E_RDA};
    launch(4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp[i]) begin
        n_miss++; $display("FAIL run_held cycle %0d: got %h want %h", i + 1, obs, exp[i]);
      end
    end
    i_Run = 1'b0;
  endtask

  initial begin
    i_Reset = 1'b1; i_Run = 1'b0; i_Continue = 1'b0;
    i_Opcode = 4'd0; i_IR_5 = 1'b0; i_IR_11 = 1'b0; i_BEN = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_opcodes;
    test_pause;
    test_reset_mid_access("ldr_rst", 4'b0110, 8);
    test_reset_mid_access("str_rst", 4'b0111, 8);
    test_run_held;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
